frame_object_sequencer: RTL and testbench

Parametrised per-frame box-list sequencer for the Pong video path. It accepts a frame description of NUM_OBJ rectangles plus an optional background clear, and replays them one box at a time to the box drawer over a valid/ready handshake. Boxes are clipped to the screen and disabled ones are skipped. A shadow buffer lets the next frame be accepted while the current one draws, and a frame-pacing counter sets the minimum frame period.

---
 rtl/frame_object_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_frame_object_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_object_sequencer.sv
// Per-frame box-list sequencer: replays an optional background clear plus NUM_OBJ
// clipped rectangles to the box drawer, with a shadow buffer for the next frame and
// a pacing counter that enforces a minimum frame period.
module frame_object_sequencer #(
    parameter int unsigned NUM_OBJ       = 4,
    parameter int unsigned COORD_W       = 9,
    parameter int unsigned COLOR_W       = 3,
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 240,
    parameter int unsigned BG_COLOR      = 0,
    parameter int unsigned FRAME_COUNT   = 833332,
    parameter int unsigned COUNT_W       = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [NUM_OBJ*COORD_W-1:0] in_obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0] in_obj_y,
    input  logic [NUM_OBJ*COORD_W-1:0] in_obj_w,
    input  logic [NUM_OBJ*COORD_W-1:0] in_obj_h,
    input  logic [NUM_OBJ*COLOR_W-1:0] in_obj_color,
    input  logic [NUM_OBJ-1:0]         in_obj_en,
    input  logic                       in_bg_en,
    input  logic                       m_ready,
    output logic                       m_valid,
    output logic [COORD_W-1:0]         out_box_x,
    output logic [COORD_W-1:0]         out_box_y,
    output logic [COORD_W-1:0]         out_box_w,
    output logic [COORD_W-1:0]         out_box_h,
    output logic [COLOR_W-1:0]         out_box_color,
    output logic                       out_busy,
    output logic                       out_frame_done
);

    localparam int unsigned IdxW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IdxW-1:0]    LastIdx  = IdxW'(NUM_OBJ - 1);
    localparam logic [COORD_W:0]   ScrWExt  = (COORD_W + 1)'(SCREEN_WIDTH);
    localparam logic [COORD_W:0]   ScrHExt  = (COORD_W + 1)'(SCREEN_HEIGHT);
    localparam logic [COORD_W-1:0] BgW      = COORD_W'(SCREEN_WIDTH);
    localparam logic [COORD_W-1:0] BgH      = COORD_W'(SCREEN_HEIGHT);
    localparam logic [COLOR_W-1:0] BgColor  = COLOR_W'(BG_COLOR);
    localparam logic [COUNT_W-1:0] FrameCnt = COUNT_W'(FRAME_COUNT);

    typedef enum logic [1:0] {StIdle, StBg, StObj, StPace} state_e;

    state_e                   state_q, state_d;
    logic                     pending_q, pending_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [COUNT_W-1:0]       count_q, count_d;

    logic [NUM_OBJ*COORD_W-1:0] sh_x_q, sh_y_q, sh_w_q, sh_h_q;
    logic [NUM_OBJ*COLOR_W-1:0] sh_color_q;
    logic [NUM_OBJ-1:0]         sh_en_q;
    logic                       sh_bg_q;

    logic [NUM_OBJ*COORD_W-1:0] act_x_q, act_y_q, act_w_q, act_h_q;
    logic [NUM_OBJ*COLOR_W-1:0] act_color_q;
    logic [NUM_OBJ-1:0]         act_en_q;

    logic                 accept;
    logic                 transfer;
    logic [COORD_W-1:0]   cur_x, cur_y, cur_w, cur_h;
    logic [COLOR_W-1:0]   cur_color;
    logic                 cur_en;
    logic [COORD_W:0]     rem_w, rem_h;
    logic [COORD_W-1:0]   clip_w, clip_h;
    logic                 slot_skip;

    assign s_ready  = !pending_q;
    assign accept   = s_valid && s_ready;
    assign out_busy = (state_q != StIdle);

    // Shadow set capture; a new accept always overwrites the shadow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_w_q     <= '0;
            sh_h_q     <= '0;
            sh_color_q <= '0;
            sh_en_q    <= '0;
            sh_bg_q    <= 1'b0;
        end else if (accept) begin
            sh_x_q     <= in_obj_x;
            sh_y_q     <= in_obj_y;
            sh_w_q     <= in_obj_w;
            sh_h_q     <= in_obj_h;
            sh_color_q <= in_obj_color;
            sh_en_q    <= in_obj_en;
            sh_bg_q    <= in_bg_en;
        end
    end

    // Active set load from the shadow when a frame starts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_x_q     <= '0;
            act_y_q     <= '0;
            act_w_q     <= '0;
            act_h_q     <= '0;
            act_color_q <= '0;
            act_en_q    <= '0;
        end else if (transfer) begin
            act_x_q     <= sh_x_q;
            act_y_q     <= sh_y_q;
            act_w_q     <= sh_w_q;
            act_h_q     <= sh_h_q;
            act_color_q <= sh_color_q;
            act_en_q    <= sh_en_q;
        end
    end

    // Control state, slot index, pacing counter and pending flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            idx_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
        end
    end

    // Current slot decode and clipping against the screen edges.
    always_comb begin
        cur_x     = act_x_q[idx_q*COORD_W +: COORD_W];
        cur_y     = act_y_q[idx_q*COORD_W +: COORD_W];
        cur_w     = act_w_q[idx_q*COORD_W +: COORD_W];
        cur_h     = act_h_q[idx_q*COORD_W +: COORD_W];
        cur_color = act_color_q[idx_q*COLOR_W +: COLOR_W];
        cur_en    = act_en_q[idx_q];
        rem_w     = ScrWExt - {1'b0, cur_x};
        rem_h     = ScrHExt - {1'b0, cur_y};
        // The remaining span is only chosen when it is <= w, so it fits COORD_W bits.
        clip_w    = ({1'b0, cur_w} < rem_w) ? cur_w : rem_w[COORD_W-1:0];
        clip_h    = ({1'b0, cur_h} < rem_h) ? cur_h : rem_h[COORD_W-1:0];
        slot_skip = !cur_en || ({1'b0, cur_x} >= ScrWExt) || ({1'b0, cur_y} >= ScrHExt) ||
                    (cur_w == '0) || (cur_h == '0);
    end

    // Next-state logic and box request outputs.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        count_d        = (count_q == FrameCnt) ? count_q : count_q + COUNT_W'(1);
        transfer       = 1'b0;
        m_valid        = 1'b0;
        out_box_x      = '0;
        out_box_y      = '0;
        out_box_w      = '0;
        out_box_h      = '0;
        out_box_color  = '0;
        out_frame_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    transfer = 1'b1;
                    count_d  = '0;
                    idx_d    = '0;
                    state_d  = sh_bg_q ? StBg : StObj;
                end
            end
            StBg: begin
                m_valid       = 1'b1;
                out_box_w     = BgW;
                out_box_h     = BgH;
                out_box_color = BgColor;
                if (m_ready) begin
                    state_d = StObj;
                end
            end
            StObj: begin
                if (!slot_skip) begin
                    m_valid       = 1'b1;
                    out_box_x     = cur_x;
                    out_box_y     = cur_y;
                    out_box_w     = clip_w;
                    out_box_h     = clip_h;
                    out_box_color = cur_color;
                end
                // Skipped slots advance unconditionally after one cycle.
                if (slot_skip || m_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StPace;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StPace: begin
                if (count_q == FrameCnt) begin
                    out_frame_done = 1'b1;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // An accept on the transfer edge wins, so the shadow stays pending.
        if (accept) begin
            pending_d = 1'b1;
        end else if (transfer) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

endmodule

// File: tb/tb_frame_object_sequencer.sv
// Directed bench for frame_object_sequencer with NUM_OBJ=3 and FRAME_COUNT=20.
module tb_frame_object_sequencer;

    localparam int N  = 3;
    localparam int CW = 9;
    localparam int KW = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic            s_valid;
    logic            s_ready;
    logic [N*CW-1:0] in_obj_x, in_obj_y, in_obj_w, in_obj_h;
    logic [N*KW-1:0] in_obj_color;
    logic [N-1:0]    in_obj_en;
    logic            in_bg_en;
    logic            m_ready;
    logic            m_valid;
    logic [CW-1:0]   out_box_x, out_box_y, out_box_w, out_box_h;
    logic [KW-1:0]   out_box_color;
    logic            out_busy;
    logic            out_frame_done;

    int checks = 0;
    int errors = 0;

    frame_object_sequencer #(
        .NUM_OBJ      (N),
        .COORD_W      (CW),
        .COLOR_W      (KW),
        .SCREEN_WIDTH (320),
        .SCREEN_HEIGHT(240),
        .BG_COLOR     (0),
        .FRAME_COUNT  (20),
        .COUNT_W      (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .in_obj_x      (in_obj_x),
        .in_obj_y      (in_obj_y),
        .in_obj_w      (in_obj_w),
        .in_obj_h      (in_obj_h),
        .in_obj_color  (in_obj_color),
        .in_obj_en     (in_obj_en),
        .in_bg_en      (in_bg_en),
        .m_ready       (m_ready),
        .m_valid       (m_valid),
        .out_box_x     (out_box_x),
        .out_box_y     (out_box_y),
        .out_box_w     (out_box_w),
        .out_box_h     (out_box_h),
        .out_box_color (out_box_color),
        .out_busy      (out_busy),
        .out_frame_done(out_frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x, y, w, h, c;
        bit en;
        bit ev;
        int ew, eh;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int w, input int h,
                            input int c, input bit en);
        in_obj_x[i*CW +: CW]     = CW'(x);
        in_obj_y[i*CW +: CW]     = CW'(y);
        in_obj_w[i*CW +: CW]     = CW'(w);
        in_obj_h[i*CW +: CW]     = CW'(h);
        in_obj_color[i*KW +: KW] = KW'(c);
        in_obj_en[i]             = en;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < N; i++) set_slot(i, 0, 0, 0, 0, 0, 1'b0);
        in_bg_en = 1'b0;
    endtask

    // Returns with the bench in the cycle after the accepting edge (DUT still IDLE).
    task automatic send();
        int n = 0;
        while (!s_ready && n < 100) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready=0 expected 1");
        end
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    // Advances until out_frame_done, reporting the cycle it was seen, then one more cycle.
    task automatic run_to_done(input int start, output int at);
        at = start;
        while (!out_frame_done && at < 200) begin
            tick();
            at++;
        end
        if (!out_frame_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no out_frame_done expected pulse");
        end
        tick();
    endtask

    task automatic chk_box(input string name, input int x, input int y, input int w,
                           input int h, input int c);
        chk({name, "_valid"}, 32'(m_valid), 32'd1);
        chk({name, "_x"}, 32'(out_box_x), x);
        chk({name, "_y"}, 32'(out_box_y), y);
        chk({name, "_w"}, 32'(out_box_w), w);
        chk({name, "_h"}, 32'(out_box_h), h);
        chk({name, "_c"}, 32'(out_box_color), c);
    endtask

    initial begin
        int  at;
        bit  ok;

        // x, y, w, h, colour, en, expect valid, expected clipped w, h
        vecs[0] = '{315, 230, 10,  48,  5, 1'b1, 1'b1, 5,   10};
        vecs[1] = '{0,   0,   320, 240, 7, 1'b1, 1'b1, 320, 240};
        vecs[2] = '{319, 239, 511, 511, 2, 1'b1, 1'b1, 1,   1};
        vecs[3] = '{10,  10,  0,   5,   1, 1'b1, 1'b0, 0,   0};
        vecs[4] = '{10,  10,  5,   0,   1, 1'b1, 1'b0, 0,   0};
        vecs[5] = '{320, 0,   5,   5,   1, 1'b1, 1'b0, 0,   0};
        vecs[6] = '{0,   240, 5,   5,   1, 1'b1, 1'b0, 0,   0};
        vecs[7] = '{5,   5,   5,   5,   1, 1'b0, 1'b0, 0,   0};
        vecs[8] = '{100, 200, 50,  45,  6, 1'b1, 1'b1, 50,  40};

        reset   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        clear_slots();
        #2;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_done", 32'(out_frame_done), 32'd0);
        chk("rst_box_w", 32'(out_box_w), 32'd0);
        #10;
        reset = 1'b0;
        tick();

        // Full frame: background then three slots back to back.
        set_slot(0, 10, 20, 30, 40, 1, 1'b1);
        set_slot(1, 100, 50, 8, 9, 2, 1'b1);
        set_slot(2, 200, 100, 16, 16, 3, 1'b1);
        in_bg_en = 1'b1;
        send();
        chk("f1_pending_s_ready", 32'(s_ready), 32'd0);
        chk("f1_idle_busy", 32'(out_busy), 32'd0);
        tick();
        chk_box("f1_bg", 0, 0, 320, 240, 0);
        chk("f1_s_ready_back", 32'(s_ready), 32'd1);
        tick();
        chk_box("f1_s0", 10, 20, 30, 40, 1);
        tick();
        chk_box("f1_s1", 100, 50, 8, 9, 2);
        tick();
        chk_box("f1_s2", 200, 100, 16, 16, 3);
        tick();
        chk("f1_pace_valid", 32'(m_valid), 32'd0);
        chk("f1_pace_busy", 32'(out_busy), 32'd1);
        run_to_done(5, at);
        chk("f1_done_cycle", at, 21);
        chk("f1_idle_after", 32'(out_busy), 32'd0);

        // Skips: slot 1 disabled, slot 2 off-screen.
        set_slot(1, 100, 50, 8, 9, 2, 1'b0);
        set_slot(2, 400, 100, 16, 16, 3, 1'b1);
        send();
        tick();
        chk_box("f2_bg", 0, 0, 320, 240, 0);
        tick();
        chk_box("f2_s0", 10, 20, 30, 40, 1);
        tick();
        chk("f2_skip1_valid", 32'(m_valid), 32'd0);
        chk("f2_skip1_w", 32'(out_box_w), 32'd0);
        tick();
        chk("f2_skip2_valid", 32'(m_valid), 32'd0);
        tick();
        chk("f2_pace_valid", 32'(m_valid), 32'd0);
        chk("f2_pace_busy", 32'(out_busy), 32'd1);
        run_to_done(5, at);
        chk("f2_done_cycle", at, 21);

        // Table: slot 0 only, clipping and skip conditions.
        for (int i = 0; i < 9; i++) begin
            clear_slots();
            set_slot(0, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c, vecs[i].en);
            send();
            tick();
            chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d_x", i), 32'(out_box_x), vecs[i].ev ? vecs[i].x : 0);
            chk($sformatf("v%0d_y", i), 32'(out_box_y), vecs[i].ev ? vecs[i].y : 0);
            chk($sformatf("v%0d_w", i), 32'(out_box_w), vecs[i].ew);
            chk($sformatf("v%0d_h", i), 32'(out_box_h), vecs[i].eh);
            chk($sformatf("v%0d_c", i), 32'(out_box_color), vecs[i].ev ? vecs[i].c : 0);
            run_to_done(1, at);
        end

        // Second frame accepted mid-draw, third offered while the shadow is full.
        clear_slots();
        set_slot(0, 10, 20, 30, 40, 1, 1'b1);
        set_slot(1, 100, 50, 8, 9, 2, 1'b1);
        set_slot(2, 200, 100, 16, 16, 3, 1'b1);
        in_bg_en = 1'b1;
        send();
        tick();
        chk("bb_a_bg_valid", 32'(m_valid), 32'd1);
        clear_slots();
        set_slot(0, 33, 44, 5, 6, 4, 1'b1);
        s_valid = 1'b1;
        tick();
        set_slot(0, 77, 44, 5, 6, 4, 1'b1);
        chk("bb_s_ready_full", 32'(s_ready), 32'd0);
        ok = 1'b1;
        at = 2;
        while (!out_frame_done && at < 200) begin
            if (s_ready) ok = 1'b0;
            tick();
            at++;
        end
        chk("bb_s_ready_held_low", 32'(ok), 32'd1);
        chk("bb_a_done_cycle", at, 21);
        s_valid = 1'b0;
        tick();
        chk("bb_idle_busy", 32'(out_busy), 32'd0);
        chk("bb_idle_s_ready", 32'(s_ready), 32'd0);
        tick();
        chk_box("bb_b_s0", 33, 44, 5, 6, 4);
        chk("bb_b_s_ready", 32'(s_ready), 32'd1);
        run_to_done(23, at);
        chk("bb_no_third", 32'(out_busy), 32'd0);

        // Back-pressure on slot 0 for five cycles.
        clear_slots();
        set_slot(0, 40, 50, 60, 70, 3, 1'b1);
        set_slot(1, 80, 90, 5, 6, 4, 1'b1);
        set_slot(2, 120, 130, 7, 8, 6, 1'b1);
        m_ready = 1'b0;
        send();
        tick();
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (!m_valid || out_box_x != 9'd40 || out_box_y != 9'd50 || out_box_w != 9'd60 ||
                out_box_h != 9'd70 || out_box_color != 3'd3) ok = 1'b0;
            tick();
        end
        chk("bp_stable", 32'(ok), 32'd1);
        chk_box("bp_still_s0", 40, 50, 60, 70, 3);
        m_ready = 1'b1;
        tick();
        chk_box("bp_s1", 80, 90, 5, 6, 4);
        tick();
        chk_box("bp_s2", 120, 130, 7, 8, 6);
        run_to_done(8, at);

        // Asynchronous reset mid-object with a frame waiting in the shadow.
        clear_slots();
        set_slot(0, 40, 50, 60, 70, 3, 1'b1);
        m_ready = 1'b0;
        send();
        tick();
        chk("rs_valid_before", 32'(m_valid), 32'd1);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("rs_shadow_full", 32'(s_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("rs_valid_drop", 32'(m_valid), 32'd0);
        chk("rs_s_ready", 32'(s_ready), 32'd1);
        chk("rs_busy", 32'(out_busy), 32'd0);
        tick();
        reset   = 1'b0;
        m_ready = 1'b1;
        ok      = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (m_valid || out_busy || !s_ready) ok = 1'b0;
        end
        chk("rs_no_restart", 32'(ok), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
